// File: rtl/tpp_bank_responder.sv
// ============================================================================
// tpp_bank_responder : 24-bank 1R1W word store with clear sweep and write stats
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tpp_bank_responder #(
    parameter int NUM_BANKS = 24,
    parameter int BANK_AW   = 9,
    parameter int BANK_DW   = 35
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_BANKS-1:0]           tppWrEnPacked,
    input  logic [NUM_BANKS*BANK_AW-1:0]   tppWrAddrPacked,
    input  logic [NUM_BANKS*BANK_DW-1:0]   tppWrDataPacked,
    input  logic [NUM_BANKS*BANK_AW-1:0]   tppRdAddrPacked,
    output logic [NUM_BANKS*BANK_DW-1:0]   tppRdDataPacked,
    input  logic                           io_i_clear_start,
    output logic                           io_o_clear_busy,
    output logic                           io_o_clear_done,
    output logic [31:0]                    io_o_wr_count,
    output logic                           io_o_drop_sticky
);

    localparam int POP_W = $clog2(NUM_BANKS + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [BANK_AW-1:0]  sweep_addr;
    logic                in_clear;
    logic [POP_W-1:0]    wr_pop;
    logic [32:0]         count_sum;

    assign in_clear = (state == CLEAR);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            sweep_addr <= '0;
        end else begin
            state      <= state_next;
            sweep_addr <= in_clear ? sweep_addr + 1'b1 : '0;
        end
    end

    always_comb begin
        state_next      = state;
        io_o_clear_busy = 1'b0;
        io_o_clear_done = 1'b0;
        case (state)
            IDLE: begin
                if (io_i_clear_start) state_next = CLEAR;
            end
            CLEAR: begin
                io_o_clear_busy = 1'b1;
                if (sweep_addr == {BANK_AW{1'b1}}) state_next = DONE;
            end
            DONE: begin
                io_o_clear_done = 1'b1;
                state_next      = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        wr_pop = '0;
        for (int b = 0; b < NUM_BANKS; b++) begin
            wr_pop = wr_pop + POP_W'(tppWrEnPacked[b]);
        end
    end

    assign count_sum = {1'b0, io_o_wr_count} + 33'(wr_pop);

    // Writes offered during a sweep are never accepted, so they are not counted.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_o_wr_count    <= '0;
            io_o_drop_sticky <= 1'b0;
        end else begin
            if (!in_clear) begin
                io_o_wr_count <= count_sum[32] ? 32'hFFFF_FFFF : count_sum[31:0];
            end
            if (in_clear && (|tppWrEnPacked)) begin
                io_o_drop_sticky <= 1'b1;
            end else if (state == IDLE && io_i_clear_start) begin
                io_o_drop_sticky <= 1'b0;
            end
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [BANK_DW-1:0] mem [2**BANK_AW];
        logic               we;
        logic [BANK_AW-1:0] wa;
        logic [BANK_AW-1:0] ra;
        logic [BANK_DW-1:0] wd;
        logic [BANK_DW-1:0] rd;

        assign we = in_clear | tppWrEnPacked[b];
        assign wa = in_clear ? sweep_addr : tppWrAddrPacked[b*BANK_AW +: BANK_AW];
        assign wd = in_clear ? '0 : tppWrDataPacked[b*BANK_DW +: BANK_DW];
        assign ra = tppRdAddrPacked[b*BANK_AW +: BANK_AW];

        // Contents are intentionally not reset; only the sweep zeroes them.
        always_ff @(posedge clock) begin
            if (we) mem[wa] <= wd;
        end

        always_ff @(posedge clock or posedge reset) begin
            if (reset)         rd <= '0;
            else if (in_clear) rd <= '0;
            else               rd <= mem[ra];
        end

        assign tppRdDataPacked[b*BANK_DW +: BANK_DW] = rd;
    end

endmodule

`default_nettype wire

// File: tb/tb_tpp_bank_responder.sv
// ============================================================================
// tb_tpp_bank_responder : directed + random checks against a behavioural model
// Revision 1.0 : initial release
// ============================================================================
`default_nettype none

module tb_tpp_bank_responder;

    localparam int NB    = 24;
    localparam int AW    = 9;
    localparam int DW    = 35;
    localparam int DEPTH = 512;

    logic                clock = 1'b0;
    logic                reset = 1'b0;
    logic [NB-1:0]       wr_en = '0;
    logic [NB*AW-1:0]    wr_addr = '0;
    logic [NB*DW-1:0]    wr_data = '0;
    logic [NB*AW-1:0]    rd_addr = '0;
    logic [NB*DW-1:0]    rd_data;
    logic                clear_start = 1'b0;
    logic                clear_busy;
    logic                clear_done;
    logic [31:0]         wr_count;
    logic                drop_sticky;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    tpp_bank_responder #(.NUM_BANKS(NB), .BANK_AW(AW), .BANK_DW(DW)) dut (
        .clock            (clock),
        .reset            (reset),
        .tppWrEnPacked    (wr_en),
        .tppWrAddrPacked  (wr_addr),
        .tppWrDataPacked  (wr_data),
        .tppRdAddrPacked  (rd_addr),
        .tppRdDataPacked  (rd_data),
        .io_i_clear_start (clear_start),
        .io_o_clear_busy  (clear_busy),
        .io_o_clear_done  (clear_done),
        .io_o_wr_count    (wr_count),
        .io_o_drop_sticky (drop_sticky)
    );

    // Behavioural model: contents, known-flags, pending sweep length, flags.
    logic [DW-1:0]   m_mem   [NB][DEPTH];
    bit              m_known [NB][DEPTH];
    logic [DW-1:0]   m_rd    [NB];
    bit              m_rd_known [NB];
    int              m_clr_rem;
    bit              m_done;
    longint unsigned m_count;
    bit              m_drop;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_clr_rem = 0;
        m_done    = 0;
        m_count   = 0;
        m_drop    = 0;
        for (int b = 0; b < NB; b++) begin
            m_rd[b]       = '0;
            m_rd_known[b] = 1;
        end
    endtask

    // Applies the inputs currently on the bus as one clock cycle of behaviour.
    task automatic model_step();
        int pc;
        int a;
        int ra;
        pc = 0;
        if (m_clr_rem > 0) begin
            a = DEPTH - m_clr_rem;
            for (int b = 0; b < NB; b++) begin
                m_mem[b][a]   = '0;
                m_known[b][a] = 1;
                m_rd[b]       = '0;
                m_rd_known[b] = 1;
            end
            if (|wr_en) m_drop = 1;
            m_clr_rem--;
            m_done = (m_clr_rem == 0);
        end else begin
            for (int b = 0; b < NB; b++) begin
                ra            = int'(rd_addr[b*AW +: AW]);
                m_rd[b]       = m_mem[b][ra];
                m_rd_known[b] = m_known[b][ra];
            end
            for (int b = 0; b < NB; b++) begin
                if (wr_en[b]) begin
                    a             = int'(wr_addr[b*AW +: AW]);
                    m_mem[b][a]   = wr_data[b*DW +: DW];
                    m_known[b][a] = 1;
                    pc++;
                end
            end
            m_count = m_count + longint'(pc);
            if (m_count > 64'hFFFF_FFFF) m_count = 64'hFFFF_FFFF;
            if (!m_done && clear_start) begin
                m_drop    = 0;
                m_clr_rem = DEPTH;
            end
            m_done = 0;
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".busy"},  64'(clear_busy),  64'(m_clr_rem > 0));
        check({tag, ".done"},  64'(clear_done),  64'(m_done));
        check({tag, ".count"}, 64'(wr_count),    m_count);
        check({tag, ".drop"},  64'(drop_sticky), 64'(m_drop));
        for (int b = 0; b < NB; b++) begin
            if (m_rd_known[b])
                check($sformatf("%s.rd%0d", tag, b), 64'(rd_data[b*DW +: DW]), 64'(m_rd[b]));
        end
    endtask

    task automatic tick(input string tag);
        model_step();
        @(posedge clock);
        #1;
        check_outputs(tag);
    endtask

    task automatic do_reset();
        wr_en       = '0;
        clear_start = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("reset");
        @(posedge clock);
        #1;
        reset = 1'b0;
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return DW'({$urandom(), $urandom()});
    endfunction

    task automatic set_all_addr(input logic [AW-1:0] wa, input logic [AW-1:0] ra);
        for (int b = 0; b < NB; b++) begin
            wr_addr[b*AW +: AW] = wa;
            rd_addr[b*AW +: AW] = ra;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int busy_cycles;
        longint unsigned count_before;
        logic [DW-1:0] v200;

        for (int b = 0; b < NB; b++)
            for (int a = 0; a < DEPTH; a++)
                m_known[b][a] = 0;

        do_reset();

        // Single-bank write then read, other banks pre-loaded at same address.
        wr_en = '1;
        set_all_addr(9'h1A3, 9'h000);
        for (int b = 0; b < NB; b++) wr_data[b*DW +: DW] = DW'(35'h100 + b);
        tick("preload");
        wr_en = '0;
        wr_en[5] = 1'b1;
        wr_data[5*DW +: DW] = 35'h5_A5A5_A5A5;
        tick("wr5");
        wr_en = '0;
        set_all_addr(9'h000, 9'h1A3);
        tick("rd5");
        check("rd5_const", 64'(rd_data[5*DW +: DW]), 64'h5_A5A5_A5A5);
        check("rd4_const", 64'(rd_data[4*DW +: DW]), 64'h104);

        // All banks at once, data = bank index.
        count_before = m_count;
        wr_en = '1;
        set_all_addr(9'd7, 9'd0);
        for (int b = 0; b < NB; b++) wr_data[b*DW +: DW] = DW'(b);
        tick("wrall");
        check("wrall_count", 64'(wr_count), count_before + 24);
        wr_en = '0;
        set_all_addr(9'd0, 9'd7);
        tick("rdall");
        for (int b = 0; b < NB; b++)
            check($sformatf("rdall_const%0d", b), 64'(rd_data[b*DW +: DW]), 64'(b));

        // Read-first on same bank/address collision.
        wr_en = '0;
        wr_en[0] = 1'b1;
        set_all_addr(9'd3, 9'd0);
        wr_data[0 +: DW] = 35'h2;
        tick("rf_pre");
        wr_data[0 +: DW] = 35'h1;
        set_all_addr(9'd3, 9'd3);
        tick("rf_same");
        check("rf_old", 64'(rd_data[0 +: DW]), 64'h2);
        wr_en = '0;
        tick("rf_next");
        check("rf_new", 64'(rd_data[0 +: DW]), 64'h1);

        // Random traffic over a small address window to provoke collisions.
        for (int i = 0; i < 300; i++) begin
            wr_en = NB'($urandom()) & NB'($urandom());
            for (int b = 0; b < NB; b++) begin
                wr_addr[b*AW +: AW] = AW'($urandom_range(0, 15));
                rd_addr[b*AW +: AW] = AW'($urandom_range(0, 15));
                wr_data[b*DW +: DW] = rnd_word();
            end
            tick("rand");
        end

        // Clear sweep with a dropped write and an ignored restart.
        wr_en = '0;
        count_before = m_count;
        clear_start = 1'b1;
        tick("clr_start");
        clear_start = 1'b0;
        busy_cycles = clear_busy ? 1 : 0;
        for (int i = 1; i < 512; i++) begin
            wr_en = '0;
            clear_start = (i == 300);
            if (i == 200) begin
                wr_en[3] = 1'b1;
                wr_data[3*DW +: DW] = 35'h123;
                wr_addr[3*AW +: AW] = 9'd10;
            end
            for (int b = 0; b < NB; b++) rd_addr[b*AW +: AW] = AW'($urandom());
            tick("clr");
            if (clear_busy) busy_cycles++;
        end
        wr_en = '0;
        clear_start = 1'b0;
        check("busy_cycles", 64'(busy_cycles), 64'd512);
        tick("clr_end");
        check("done_pulse", 64'(clear_done), 64'd1);
        check("done_busy", 64'(clear_busy), 64'd0);
        clear_start = 1'b1;
        tick("done_restart");
        clear_start = 1'b0;
        check("no_restart", 64'(clear_busy), 64'd0);
        check("drop_set", 64'(drop_sticky), 64'd1);
        check("clr_count", 64'(wr_count), count_before);
        for (int a = 0; a < DEPTH; a++) begin
            set_all_addr(9'd0, AW'(a));
            tick("post_clr");
        end
        set_all_addr(9'd0, 9'd10);
        tick("dropped");
        check("dropped_const", 64'(rd_data[3*DW +: DW]), 64'd0);

        // Saturating write counter.
        wr_en = '1;
        set_all_addr(9'd20, 9'd0);
        for (int b = 0; b < NB; b++) wr_data[b*DW +: DW] = rnd_word();
        force dut.io_o_wr_count = 32'hFFFF_FFF0;
        #1;
        release dut.io_o_wr_count;
        m_count = 64'hFFFF_FFF0;
        tick("sat1");
        check("sat1_const", 64'(wr_count), 64'hFFFF_FFFF);
        tick("sat2");
        check("sat2_const", 64'(wr_count), 64'hFFFF_FFFF);
        wr_en = '0;

        // Reset during a sweep keeps partially cleared content.
        wr_en = '1;
        for (int a = 0; a <= 100; a++) begin
            set_all_addr((a == 100) ? 9'd200 : AW'(a), 9'd0);
            for (int b = 0; b < NB; b++) wr_data[b*DW +: DW] = rnd_word();
            tick("pre_abort");
        end
        wr_en = '0;
        v200 = m_mem[0][200];
        clear_start = 1'b1;
        tick("abort_start");
        clear_start = 1'b0;
        check("drop_cleared", 64'(drop_sticky), 64'd0);
        for (int i = 0; i < 100; i++) tick("abort_sweep");
        #1;
        reset = 1'b1;
        #1;
        model_reset();
        check("abort_busy", 64'(clear_busy), 64'd0);
        check_outputs("abort_rst");
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 5; i++) tick("abort_idle");
        for (int a = 0; a <= 101; a++) begin
            set_all_addr(9'd0, (a == 100) ? 9'd200 : AW'(a));
            tick("abort_rd");
            if (a == 99)  check("abort_rd99", 64'(rd_data[0 +: DW]), 64'd0);
            if (a == 100) check("abort_rd200", 64'(rd_data[0 +: DW]), 64'(v200));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
